// File: rtl/repeated_add_multiplier_pkg.sv
// repeated_add_multiplier_pkg: shared FSM state encoding and default widths
package repeated_add_multiplier_pkg;
  localparam int WIDTH_IN_DEF = 8;
  localparam int WIDTH_OUT_DEF = 16;
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
endpackage

// File: rtl/repeated_add_multiplier_if.sv
// repeated_add_multiplier_if: operand/result bundle between driver and multiplier
interface repeated_add_multiplier_if
  import repeated_add_multiplier_pkg::*;
#(
  parameter int WIDTH_IN = WIDTH_IN_DEF,
  parameter int WIDTH_OUT = WIDTH_OUT_DEF
) ();
  logic [WIDTH_IN-1:0] multiplicand;
  logic [WIDTH_IN-1:0] multiplier;
  logic [WIDTH_OUT-1:0] product;
  logic done;
  modport master (output multiplicand, multiplier, input product, done);
  modport slave (input multiplicand, multiplier, output product, done);
endinterface

// File: rtl/repeated_add_down_counter.sv
// repeated_add_down_counter: loadable down-counter with zero flag
module repeated_add_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  always_ff @(posedge CLK) begin
    if (load) count <= d;
    else if (dec) count <= count - WIDTH'(1);
  end
  assign zero = count == '0;
endmodule

// File: rtl/repeated_add_multiplier.sv
// repeated_add_multiplier: unsigned multiply by repeated addition after reset release
module repeated_add_multiplier
  import repeated_add_multiplier_pkg::*;
#(
  parameter int WIDTH_IN = WIDTH_IN_DEF,
  parameter int WIDTH_OUT = WIDTH_OUT_DEF
) (
  input logic CLK,
  input logic RST_N,
  repeated_add_multiplier_if.slave bus
);
  state_t state, state_nxt;
  logic [WIDTH_IN-1:0] operand, count;
  logic [WIDTH_OUT-1:0] acc;
  logic zero, step;
  repeated_add_down_counter #(.WIDTH(WIDTH_IN)) u_cnt (
    .CLK(CLK),
    .load(!RST_N),
    .dec(step),
    .d(bus.multiplier),
    .count(count),
    .zero(zero)
  );
  // the edge that consumes the last count also lands in DONE, keeping done aligned with the final sum
  always_comb begin
    step = state != DONE && !zero;
    state_nxt = (state == DONE || zero || count == WIDTH_IN'(1)) ? DONE : RUN;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= LOAD;
      acc <= '0;
      operand <= bus.multiplicand;
    end else begin
      state <= state_nxt;
      if (step) acc <= acc + WIDTH_OUT'(operand);
    end
  end
  assign bus.product = acc;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_repeated_add_multiplier.sv
// tb_repeated_add_multiplier: vector table plus corner sequences, checked through an expected-result queue
module tb_repeated_add_multiplier;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] p;
  } vec_t;
  logic CLK = 0;
  logic RST_N = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  vec_t vecs[12];
  repeated_add_multiplier_if #(.WIDTH_IN(8), .WIDTH_OUT(16)) bus ();
  repeated_add_multiplier #(.WIDTH_IN(8), .WIDTH_OUT(16)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic reset_load(input logic [7:0] a, input logic [7:0] b, input int cycles);
    @(negedge CLK);
    RST_N = 0;
    bus.multiplicand = a;
    bus.multiplier = b;
    repeat (cycles) @(negedge CLK);
    check("reset product", 32'(bus.product), 0);
    check("reset done", 32'(bus.done), 0);
    RST_N = 1;
  endtask
  task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int edges = 0;
    logic [15:0] exp;
    reset_load(a, b, 2);
    exp_q.push_back(p);
    bus.multiplicand = ~a;
    bus.multiplier = ~b;
    do begin
      @(negedge CLK);
      edges++;
    end while (!bus.done && edges < 300);
    check("latency", 32'(edges), (b == 0) ? 32'd1 : 32'(b));
    exp = exp_q.pop_front();
    check("product", 32'(bus.product), 32'(exp));
    repeat (2) @(negedge CLK);
    check("hold product", 32'(bus.product), 32'(exp));
    check("hold done", 32'(bus.done), 1);
  endtask
  initial begin
    logic [7:0] ra, rb;
    bus.multiplicand = 0;
    bus.multiplier = 0;
    vecs[0]  = '{8'd0,   8'd0,   16'd0};
    vecs[1]  = '{8'd7,   8'd5,   16'd35};
    vecs[2]  = '{8'd255, 8'd255, 16'd65025};
    vecs[3]  = '{8'd1,   8'd1,   16'd1};
    vecs[4]  = '{8'd255, 8'd1,   16'd255};
    vecs[5]  = '{8'd1,   8'd255, 16'd255};
    vecs[6]  = '{8'd0,   8'd255, 16'd0};
    vecs[7]  = '{8'd255, 8'd0,   16'd0};
    vecs[8]  = '{8'd9,   8'd4,   16'd36};
    vecs[9]  = '{8'd12,  8'd34,  16'd408};
    vecs[10] = '{8'd100, 8'd200, 16'd20000};
    vecs[11] = '{8'd128, 8'd2,   16'd256};
    for (int i = 0; i < 12; i++) run_vec(vecs[i].a, vecs[i].b, vecs[i].p);
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_vec(ra, rb, 16'(ra) * 16'(rb));
    end
    reset_load(8'd7, 8'd5, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      check("step product", 32'(bus.product), 32'(7 * k));
      check("step done", 32'(bus.done), (k == 5) ? 32'd1 : 32'd0);
    end
    reset_load(8'd3, 8'd200, 1);
    repeat (50) @(negedge CLK);
    check("abort partial", 32'(bus.product), 150);
    check("abort partial done", 32'(bus.done), 0);
    reset_load(8'd4, 8'd2, 1);
    @(negedge CLK);
    check("abort step1", 32'(bus.product), 4);
    check("abort step1 done", 32'(bus.done), 0);
    @(negedge CLK);
    check("abort result", 32'(bus.product), 8);
    check("abort result done", 32'(bus.done), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/repeated_add_multiplier.md
REPEATED_ADD_MULTIPLIER -- requirements
Module: repeated_add_multiplier

Interface
REQ-001 Parameter WIDTH_IN, default 8, operand width in bits.
REQ-002 Parameter WIDTH_OUT, default 16, product width in bits; SHALL be >= 2*WIDTH_IN for exact results.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 multiplicand  input  WIDTH_IN  unsigned value added on each iteration.
REQ-006 multiplier  input  WIDTH_IN  unsigned iteration count.
REQ-007 product  output  WIDTH_OUT  unsigned accumulator value, registered.
REQ-008 done  output  1  high once product holds the final result; may be left unconnected.

Function
REQ-009 While RST_N is low at a rising edge, the block SHALL capture multiplicand into an internal operand register and multiplier into an internal down-counter.
REQ-010 While RST_N is low at a rising edge, the block SHALL clear the accumulator to 0 and enter state LOAD.
REQ-011 States: LOAD (reset held), RUN (counter != 0), DONE (counter == 0).
REQ-012 At the first rising edge with RST_N high, the block SHALL go to RUN if the captured count is nonzero, otherwise to DONE.
REQ-013 In RUN, each rising edge SHALL add the captured multiplicand to the accumulator, modulo 2^WIDTH_OUT, and decrement the counter by 1.
REQ-014 In RUN, the block SHALL move to DONE on the edge at which the counter reaches 0.
REQ-015 In DONE, the accumulator and counter SHALL hold; DONE is left only by reset.
REQ-016 Result: product SHALL equal multiplicand*multiplier exactly after N = multiplier rising edges following reset release.
REQ-017 Latency: N rising edges with RST_N high; N = 0 gives product = 0 immediately, N = 2^WIDTH_IN - 1 is the maximum.
REQ-018 Intermediate values: after k iterations product SHALL equal k*multiplicand (monotonic, no glitch values).
REQ-019 Operand inputs SHALL be ignored while RST_N is high; changes take effect only through a new reset.
REQ-020 done SHALL be 0 in LOAD and RUN, and 1 in DONE, registered and aligned with the final product.
REQ-021 Asserting RST_N low mid-computation SHALL abort the computation on that edge: accumulator cleared, operands recaptured, no partial result retained.
REQ-022 Ports are unsigned only; no signed mode.

Reset
REQ-023 Reset values: product = 0, done = 0, state = LOAD, counter = captured multiplier, operand = captured multiplicand.
REQ-024 A single low cycle on RST_N sampled at a rising edge SHALL be sufficient for a complete reset.
REQ-025 No asynchronous reset paths SHALL exist.

Structure
REQ-026 A shared package SHALL hold the state enum (LOAD/RUN/DONE) and the default width constants (8, 16).
REQ-027 One sub-module is natural: repeated_add_down_counter (WIDTH_IN loadable down-counter with zero flag).
REQ-028 The accumulator and the FSM SHALL reside in the top module.

Verification
REQ-029 multiplicand=0, multiplier=0, reset 2 cycles then release -> product=0 and done=1 at the first edge after release.
REQ-030 multiplicand=7, multiplier=5 -> product steps 7,14,21,28,35; equals 35 with done=1 after 5 edges, then holds.
REQ-031 multiplicand=255, multiplier=255 -> product=65025 after exactly 255 edges with no overflow.
REQ-032 multiplicand=3, multiplier=200; reset asserted after 50 edges with operands changed to 4 and 2 -> product cleared to 0, then 8 after 2 edges.
REQ-033 multiplicand=9, multiplier=4; inputs changed to 1 and 1 after reset release -> result still 36 after 4 edges.
REQ-034 Exhaustive sweep of all 256x256 operand pairs, each preceded by a 2-cycle reset -> product equals i*j within j edges for every pair.
